inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//  Program-counter and fetch sequencer; sits directly upstream of the instruction ROM.
//  Drives InstAddress into the ROM and sequences it: start, sequential fetch, stall,
//  taken branches (relative or absolute) and halt. The ROM read is combinational, so
//  the instruction for InstAddress is valid in the same cycle.
//  Reports Done and a retired-instruction count to the testbench/top level.
// PARAMETERS
//  IW   10  PC / InstAddress width; instruction memory depth = 2**IW
//  OW    6  signed relative branch offset width (OW <= IW)
//  CW   16  retired-instruction counter width
// PORTS
//  Clk          in   1   single clock, rising-edge
//  ResetN       in   1   asynchronous, active-low reset
//  Start        in   1   1-cycle pulse: (re)start program at StartAddr
//  StartAddr    in   IW  program entry address, sampled when Start=1
//  Stall        in   1   hold PC this cycle (downstream not ready)
//  Halt         in   1   decoded halt instruction at current PC
//  BranchTaken  in   1   decoded branch at current PC, condition true
//  BranchAbs    in   1   1: target = Target; 0: target = PC + sext(Offset)
//  Offset       in   OW  signed relative offset (two's complement)
//  Target       in   IW  absolute target (from branch LUT in decoder)
//  InstAddress  out  IW  PC presented to the instruction ROM
//  Running      out  1   state == RUN
//  Done         out  1   state == HALT; held until next Start
//  InstCount    out  CW  instructions retired since last Start
// BEHAVIOUR
//  Reset (async, ResetN=0): state=IDLE, PC=0, Done=0, Running=0, InstCount=0.
//  States: IDLE -> RUN on Start; RUN -> HALT on Halt & !Stall; any -> RUN on Start.
//  All outputs are registered or decoded from registered state only; no comb in->out path.
//  Per-cycle priority (highest first), evaluated at the rising edge:
//   1 Start: PC<=StartAddr, InstCount<=0, state<=RUN (from IDLE, RUN or HALT).
//   2 state!=RUN: PC, InstCount unchanged.
//   3 Stall: PC, InstCount unchanged; Halt/BranchTaken ignored this cycle.
//   4 Halt: state<=HALT, PC unchanged, InstCount+=1 (halt retires).
//   5 BranchTaken&BranchAbs: PC<=Target, InstCount+=1.
//   6 BranchTaken&!BranchAbs: PC<=PC+sext(Offset), InstCount+=1.
//   7 otherwise: PC<=PC+1, InstCount+=1.
//  Latency: Start at edge N -> InstAddress=StartAddr after edge N; first retire at N+1.
//  Arithmetic: Offset sign-extended to IW; all PC updates modulo 2**IW (2**IW-1 + 1 -> 0;
//   0 + (-1) -> 2**IW-1). Offset=0 taken branch = self-loop, legal.
//  InstCount saturates at 2**CW-1; no wrap.
//  Halt and BranchTaken together: Halt wins. BranchAbs ignored unless BranchTaken.
//  Reset mid-RUN: immediate return to reset values; Start required to resume.
//  Done rises the cycle after the halting edge, clears on the edge Start is sampled.
// STRUCTURE
//  fetch_pkg: typedef enum logic [1:0] {IDLE, RUN, HALT} fetch_state_t;
//   localparams for default IW/OW/CW shared with InstROM and the decoder.
//  Sub-module next_pc_calc (combinational): PC, BranchTaken, BranchAbs, Offset,
//   Target -> next sequential/branch PC, includes sign extension and wrap.
//  Top: state register, PC register, saturating counter, priority mux.
// TESTING
//  T1 reset: ResetN=0 mid-RUN at PC=37 -> same cycle InstAddress=0, Done=0, Running=0, InstCount=0.
//  T2 start+seq: Start, StartAddr=5, 4 idle cycles -> InstAddress 5,6,7,8,9; InstCount=4.
//  T3 branches at PC=20: rel Offset=-3 -> 17; rel Offset=+31 -> 51; abs Target=900 -> 900.
//  T4 wrap: PC=1023 seq -> 0; PC=2 rel Offset=-4 -> 1022 (IW=10).
//  T5 stall/halt: Stall=1 with Halt=1 -> no change; Stall=0 Halt=1 -> Done=1 next cycle,
//     PC held; later Start with StartAddr=0 -> Done=0, PC=0, InstCount=0.
//  T6 priority: Start with BranchTaken=1 & Halt=1 in RUN -> PC=StartAddr, state RUN;
//     CW=4 run 20 instrs -> InstCount sticks at 15.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and default widths, also used by the instruction ROM and the decoder.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } fetch_state_t;

    localparam int unsigned DefIw = 10;
    localparam int unsigned DefOw = 6;
    localparam int unsigned DefCw = 16;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC generator: sequential increment or taken branch (relative or absolute).
module next_pc_calc #(
    parameter int unsigned IW = 10,
    parameter int unsigned OW = 6
) (
    input  logic [IW-1:0] pc,
    input  logic          branch_taken,
    input  logic          branch_abs,
    input  logic [OW-1:0] offset,
    input  logic [IW-1:0] target,
    output logic [IW-1:0] next_pc
);

    logic [IW-1:0] offset_ext;

    // Width cast of a signed operand sign-extends; IW-bit sums wrap modulo 2**IW.
    assign offset_ext = IW'($signed(offset));

    always_comb begin
        next_pc = pc + IW'(1);
        if (branch_taken) begin
            next_pc = branch_abs ? target : pc + offset_ext;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Program counter and fetch sequencer driving the instruction ROM address.
module inst_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned IW = DefIw,
    parameter int unsigned OW = DefOw,
    parameter int unsigned CW = DefCw
) (
    input  logic          Clk,
    input  logic          ResetN,
    input  logic          Start,
    input  logic [IW-1:0] StartAddr,
    input  logic          Stall,
    input  logic          Halt,
    input  logic          BranchTaken,
    input  logic          BranchAbs,
    input  logic [OW-1:0] Offset,
    input  logic [IW-1:0] Target,
    output logic [IW-1:0] InstAddress,
    output logic          Running,
    output logic          Done,
    output logic [CW-1:0] InstCount
);

    fetch_state_t  state_q, state_d;
    logic [IW-1:0] pc_q, pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [IW-1:0] next_pc;
    logic [CW-1:0] count_inc;

    next_pc_calc #(
        .IW(IW),
        .OW(OW)
    ) u_next_pc_calc (
        .pc          (pc_q),
        .branch_taken(BranchTaken),
        .branch_abs  (BranchAbs),
        .offset      (Offset),
        .target      (Target),
        .next_pc     (next_pc)
    );

    assign count_inc = (count_q == {CW{1'b1}}) ? count_q : count_q + CW'(1);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        if (Start) begin
            state_d = RUN;
            pc_d    = StartAddr;
            count_d = '0;
        end else if (state_q == RUN && !Stall) begin
            count_d = count_inc;
            if (Halt) begin
                state_d = HALT;
            end else begin
                pc_d = next_pc;
            end
        end
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= IDLE;
            pc_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    assign InstAddress = pc_q;
    assign Running     = (state_q == RUN);
    assign Done        = (state_q == HALT);
    assign InstCount   = count_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed scoreboard bench for inst_fetch; a CW=4 twin shares all inputs to check saturation.
module tb_inst_fetch;

    logic        Clk;
    logic        ResetN;
    logic        Start;
    logic [9:0]  StartAddr;
    logic        Stall;
    logic        Halt;
    logic        BranchTaken;
    logic        BranchAbs;
    logic [5:0]  Offset;
    logic [9:0]  Target;
    logic [9:0]  InstAddress;
    logic        Running;
    logic        Done;
    logic [15:0] InstCount;
    logic [9:0]  InstAddress4;
    logic        Running4;
    logic        Done4;
    logic [3:0]  InstCount4;

    typedef struct {
        string       name;
        logic [9:0]  addr;
        logic        run;
        logic        done;
        logic [15:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    event mon_now;

    inst_fetch #(.IW(10), .OW(6), .CW(16)) dut (
        .Clk        (Clk),
        .ResetN     (ResetN),
        .Start      (Start),
        .StartAddr  (StartAddr),
        .Stall      (Stall),
        .Halt       (Halt),
        .BranchTaken(BranchTaken),
        .BranchAbs  (BranchAbs),
        .Offset     (Offset),
        .Target     (Target),
        .InstAddress(InstAddress),
        .Running    (Running),
        .Done       (Done),
        .InstCount  (InstCount)
    );

    inst_fetch #(.IW(10), .OW(6), .CW(4)) dut4 (
        .Clk        (Clk),
        .ResetN     (ResetN),
        .Start      (Start),
        .StartAddr  (StartAddr),
        .Stall      (Stall),
        .Halt       (Halt),
        .BranchTaken(BranchTaken),
        .BranchAbs  (BranchAbs),
        .Offset     (Offset),
        .Target     (Target),
        .InstAddress(InstAddress4),
        .Running    (Running4),
        .Done       (Done4),
        .InstCount  (InstCount4)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic cmp(input string name, input string field, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s.%s: got %0d, expected %0d", name, field, act, req);
        end
    endtask

    // Monitor: drains the scoreboard on every falling edge, or on demand for async checks.
    always begin
        @(negedge Clk or mon_now);
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp(e.name, "addr",  int'(InstAddress), int'(e.addr));
            cmp(e.name, "run",   int'(Running),     int'(e.run));
            cmp(e.name, "done",  int'(Done),        int'(e.done));
            cmp(e.name, "cnt",   int'(InstCount),   int'(e.cnt));
            cmp(e.name, "cnt4",  int'(InstCount4),  int'(e.cnt4));
        end
    end

    function automatic exp_t mk(input string name, input logic [9:0] addr, input logic run,
                                input logic done, input logic [15:0] cnt);
        exp_t e;
        e.name = name;
        e.addr = addr;
        e.run  = run;
        e.done = done;
        e.cnt  = cnt;
        e.cnt4 = (cnt > 16'd15) ? 4'd15 : cnt[3:0];
        return e;
    endfunction

    // One clock: apply inputs, take the edge, queue the state expected after it.
    task automatic step(input string name, input logic st, input logic [9:0] sa,
                        input logic stl, input logic hlt, input logic bt, input logic ba,
                        input logic [5:0] off, input logic [9:0] tgt,
                        input logic [9:0] e_addr, input logic e_run, input logic e_done,
                        input logic [15:0] e_cnt);
        Start       = st;
        StartAddr   = sa;
        Stall       = stl;
        Halt        = hlt;
        BranchTaken = bt;
        BranchAbs   = ba;
        Offset      = off;
        Target      = tgt;
        @(posedge Clk);
        exp_q.push_back(mk(name, e_addr, e_run, e_done, e_cnt));
        #1;
    endtask

    task automatic idle(input string name, input logic [9:0] e_addr, input logic e_run,
                        input logic e_done, input logic [15:0] e_cnt);
        step(name, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 10'd0,
             e_addr, e_run, e_done, e_cnt);
    endtask

    task automatic start(input string name, input logic [9:0] sa);
        step(name, 1'b1, sa, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 10'd0, sa, 1'b1, 1'b0, 16'd0);
    endtask

    initial begin
        int waited;
        ResetN = 1'b0;
        Start = 1'b0; StartAddr = '0; Stall = 1'b0; Halt = 1'b0;
        BranchTaken = 1'b0; BranchAbs = 1'b0; Offset = '0; Target = '0;
        #12 ResetN = 1'b1;

        idle("reset_state", 10'd0, 1'b0, 1'b0, 16'd0);

        // Sequential fetch from 5
        start("t2_start", 10'd5);
        idle("t2_seq1", 10'd6, 1'b1, 1'b0, 16'd1);
        idle("t2_seq2", 10'd7, 1'b1, 1'b0, 16'd2);
        idle("t2_seq3", 10'd8, 1'b1, 1'b0, 16'd3);
        idle("t2_seq4", 10'd9, 1'b1, 1'b0, 16'd4);

        // Branches from PC=20
        start("t3_start_a", 10'd20);
        step("t3_rel_m3", 1'b0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 6'h3D, 10'd0,
             10'd17, 1'b1, 1'b0, 16'd1);
        start("t3_start_b", 10'd20);
        step("t3_rel_p31", 1'b0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 6'h1F, 10'd0,
             10'd51, 1'b1, 1'b0, 16'd1);
        start("t3_start_c", 10'd20);
        step("t3_abs_900", 1'b0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 6'h3D, 10'd900,
             10'd900, 1'b1, 1'b0, 16'd1);
        step("t3_abs_not_taken", 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'h00, 10'd300,
             10'd901, 1'b1, 1'b0, 16'd2);
        step("t3_self_loop", 1'b0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 6'h00, 10'd0,
             10'd901, 1'b1, 1'b0, 16'd3);

        // Wrap-around in both directions
        start("t4_start_top", 10'd1023);
        idle("t4_wrap_up", 10'd0, 1'b1, 1'b0, 16'd1);
        start("t4_start_2", 10'd2);
        step("t4_wrap_down", 1'b0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 6'h3C, 10'd0,
             10'd1022, 1'b1, 1'b0, 16'd1);

        // Stall masks halt/branch; halt retires and holds PC
        start("t5_start", 10'd40);
        step("t5_stall_halt", 1'b0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 10'd0,
             10'd40, 1'b1, 1'b0, 16'd0);
        step("t5_stall_branch", 1'b0, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1, 6'd0, 10'd700,
             10'd40, 1'b1, 1'b0, 16'd0);
        step("t5_halt_branch", 1'b0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 6'd0, 10'd700,
             10'd40, 1'b0, 1'b1, 16'd1);
        idle("t5_halted_hold", 10'd40, 1'b0, 1'b1, 16'd1);
        step("t5_halted_branch", 1'b0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0, 10'd500,
             10'd40, 1'b0, 1'b1, 16'd1);
        start("t5_restart_0", 10'd0);

        // Start beats simultaneous branch and halt; then saturate the CW=4 counter
        step("t6_start_prio", 1'b1, 10'd100, 1'b0, 1'b1, 1'b1, 1'b1, 6'd0, 10'd800,
             10'd100, 1'b1, 1'b0, 16'd0);
        for (int i = 1; i <= 20; i++) begin
            idle($sformatf("t6_run%0d", i), 10'(100 + i), 1'b1, 1'b0, 16'(i));
        end

        // Asynchronous reset mid-run, checked before the next clock edge
        start("t1_start_37", 10'd37);
        @(negedge Clk);
        #1 ResetN = 1'b0;
        #1 exp_q.push_back(mk("t1_async_reset", 10'd0, 1'b0, 1'b0, 16'd0));
        ->mon_now;
        #1 ResetN = 1'b1;
        idle("t1_stay_idle", 10'd0, 1'b0, 1'b0, 16'd0);

        waited = 0;
        while (exp_q.size() > 0 && waited < 5) begin
            @(negedge Clk);
            #1 waited++;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
